// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles 32-bit instructions from two 16-bit memory reads and
// hands them to decode over a valid/ready handshake, with branch redirect support.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc
);

  typedef enum logic [1:0] {StIdle, StFetchHi, StFetchLo, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hi_q, hi_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        redirect;

  // Redirects are ignored only while idling out of reset.
  assign redirect = branch_taken && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = StFetchHi;
      StFetchHi: begin
        if (redirect)      state_d = StFetchHi;
        else if (imem_ack) state_d = StFetchLo;
      end
      StFetchLo: begin
        if (redirect)      state_d = StFetchHi;
        else if (imem_ack) state_d = StHold;
      end
      StHold: begin
        if (redirect || instr_ready) state_d = StFetchHi;
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      StFetchHi: imem_req = 1'b1;
      StFetchLo: begin
        imem_req  = 1'b1;
        imem_addr = pc_q + 16'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    hi_d       = hi_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (redirect) begin
      // Any ack in this cycle is discarded; a held instruction is dropped.
      pc_d    = {branch_target[15:2], 2'b00};
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StFetchHi: begin
          if (imem_ack) hi_d = imem_rdata;
        end
        StFetchLo: begin
          if (imem_ack) begin
            instr_d    = {hi_q, imem_rdata};
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + 16'd4;
          end
        end
        StHold: begin
          if (instr_ready) valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      hi_q       <= 16'h0000;
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      hi_q       <= hi_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  // Opcode reads as R-format while nothing is valid.
  assign opcode      = valid_q ? instr_q[31:26] : 6'b000000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of fetch vectors with wait-state memory, plus hand
// sequences for hold, redirects, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, instr_ready, branch_taken;
  logic [15:0] imem_addr, imem_rdata, instr_pc, branch_target, pc;
  logic [31:0] instr;
  logic [5:0]  opcode;

  logic        imem_req2, imem_ack2, instr_valid2;
  logic        instr_ready2 = 1'b0;
  logic        branch_taken2 = 1'b0;
  logic [15:0] branch_target2 = 16'h0000;
  logic [15:0] imem_addr2, imem_rdata2, instr_pc2, pc2;
  logic [31:0] instr2;
  logic [5:0]  opcode2;

  int n_cmp = 0;
  int n_bad = 0;
  int nwait = 0;
  int wcnt;
  logic [15:0] addr_q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_half(input logic [15:0] a);
    case (a)
      16'h0000: mem_half = 16'h8C22;
      16'h0002: mem_half = 16'h0004;
      16'h0004: mem_half = 16'h2001;
      16'h0006: mem_half = 16'h0005;
      16'h0008: mem_half = 16'hAC41;
      16'h000A: mem_half = 16'h0008;
      16'h000C: mem_half = 16'h1000;
      16'h000E: mem_half = 16'hFFFF;
      16'h0100: mem_half = 16'h0128;
      16'h0102: mem_half = 16'h1820;
      16'hFFFC: mem_half = 16'h3C01;
      16'hFFFE: mem_half = 16'h1234;
      default:  mem_half = ~a;
    endcase
  endfunction

  // Memory with nwait wait cycles before each ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_ack    = imem_req && (wcnt >= nwait);
  assign imem_rdata  = mem_half(imem_addr);
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = mem_half(imem_addr2);

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr(instr2), .opcode(opcode2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(instr_ready2),
    .branch_taken(branch_taken2), .branch_target(branch_target2), .pc(pc2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for instr_valid at negedges, logging requested addresses; lat counts rising edges.
  task automatic fetch(input bit from_reset, output int lat);
    bit done = 1'b0;
    lat = from_reset ? 1 : 0;
    addr_q.delete();
    while (!done) begin
      @(negedge clk);
      if (instr_valid) begin
        done = 1'b1;
      end else begin
        if (imem_req) addr_q.push_back(imem_addr);
        @(posedge clk);
        lat++;
        if (lat > 60) begin
          n_cmp++;
          n_bad++;
          $display("FAIL fetch_timeout: instr_valid still 0 after %0d cycles, required 1", lat);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(posedge clk);
    #1 instr_ready = 1'b0;
  endtask

  // The release edge counts as the first edge after rst_n rises.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    int          nw;
    int          lat;
    logic [15:0] ipc;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat;
    logic [15:0] ea;
    logic [5:0]  eop;
    vecs[0] = '{1'b1, 0, 4, 16'h0000, 32'h8C220004};
    vecs[1] = '{1'b0, 0, 2, 16'h0004, 32'h20010005};
    vecs[2] = '{1'b0, 1, 4, 16'h0008, 32'hAC410008};
    vecs[3] = '{1'b0, 2, 6, 16'h000C, 32'h1000FFFF};
    vecs[4] = '{1'b1, 2, 8, 16'h0000, 32'h8C220004};
    vecs[5] = '{1'b0, 0, 2, 16'h0004, 32'h20010005};

    rst_n = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_pc_wrapdut", {16'd0, pc2}, 32'h0000FFFC);

    for (int i = 0; i < 6; i++) begin
      nwait = vecs[i].nw;
      if (vecs[i].rst) do_reset();
      else accept();
      fetch(vecs[i].rst, lat);
      eop = vecs[i].ins[31:26];
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_instr", i), instr, vecs[i].ins);
      check($sformatf("v%0d_opcode", i), {26'd0, opcode}, {26'd0, eop});
      check($sformatf("v%0d_instr_pc", i), {16'd0, instr_pc}, {16'd0, vecs[i].ipc});
      check($sformatf("v%0d_addr_count", i), addr_q.size(), 2 * (vecs[i].nw + 1));
      for (int j = 0; j < addr_q.size(); j++) begin
        ea = (j <= vecs[i].nw) ? vecs[i].ipc : vecs[i].ipc + 16'd2;
        check($sformatf("v%0d_addr%0d", i, j), {16'd0, addr_q[j]}, {16'd0, ea});
      end
      if (i == 0) begin
        check("wrap_valid", {31'd0, instr_valid2}, 32'd1);
        check("wrap_instr", instr2, 32'h3C011234);
        check("wrap_opcode", {26'd0, opcode2}, 32'h0000000F);
        check("wrap_instr_pc", {16'd0, instr_pc2}, 32'h0000FFFC);
        check("wrap_pc", {16'd0, pc2}, 32'h00000000);
      end
    end

    // Held instruction stays stable with no requests while decode stalls.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h20010005);
      check("hold_instr_pc", {16'd0, instr_pc}, 32'h00000004);
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    accept();
    fetch(1'b0, lat);
    check("resume_addr", (addr_q.size() > 0) ? {16'd0, addr_q[0]} : 32'hFFFFFFFF, 32'h8);
    check("resume_instr_pc", {16'd0, instr_pc}, 32'h00000008);

    // Redirect in FETCH_LO with a same-cycle ack.
    accept();
    @(posedge clk);
    @(negedge clk);
    branch_taken = 1'b1;
    branch_target = 16'h0102;
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("br_lo_valid", {31'd0, instr_valid}, 32'd0);
    check("br_lo_addr", {16'd0, imem_addr}, 32'h00000100);
    check("br_lo_req", {31'd0, imem_req}, 32'd1);
    fetch(1'b0, lat);
    check("br_lo_instr_pc", {16'd0, instr_pc}, 32'h00000100);
    check("br_lo_instr", instr, 32'h01281820);

    // Redirect in HOLD with instr_ready in the same cycle; misaligned target.
    instr_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 16'h000B;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    check("br_hold_valid", {31'd0, instr_valid}, 32'd0);
    check("br_hold_addr", {16'd0, imem_addr}, 32'h00000008);
    fetch(1'b0, lat);
    check("br_hold_instr_pc", {16'd0, instr_pc}, 32'h00000008);
    check("br_hold_instr", instr, 32'hAC410008);

    // Asynchronous reset in the middle of FETCH_LO.
    accept();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_req", {31'd0, imem_req}, 32'd0);
    check("areset_valid", {31'd0, instr_valid}, 32'd0);
    check("areset_instr", instr, 32'd0);
    check("areset_instr_pc", {16'd0, instr_pc}, 32'd0);
    check("areset_pc", {16'd0, pc}, 32'd0);
    check("areset_wrap_pc", {16'd0, pc2}, 32'h0000FFFC);

    // branch_taken during IDLE is ignored.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    branch_taken = 1'b1;
    branch_target = 16'h0200;
    @(posedge clk);
    #1 branch_taken = 1'b0;
    @(negedge clk);
    check("br_idle_addr", {16'd0, imem_addr}, 32'h00000000);
    check("br_idle_req", {31'd0, imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
